// File: rtl/beamform_pkg.sv
// Shared beamforming defaults and the width-generic clamp used by apod_sum
// and the envelope stage.
package beamform_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_COEF_WIDTH = 12;
    localparam int DEF_COEF_FRAC  = 11;
    localparam int COEF_UNITY     = 1 << DEF_COEF_FRAC;

    // Clamp a signed value to the range of a w-bit signed number (w <= 63).
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x,
                                                     input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree: N signed inputs, one register per level, with a
// pipeline enable and a valid bit that travels alongside the data.
module adder_tree_pipe #(
    parameter  int N   = 8,
    parameter  int W   = 29,
    localparam int LVL = $clog2(N),
    localparam int OW  = W + LVL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic [N*W-1:0]       data_i,
    output logic                 valid_o,
    output logic signed [OW-1:0] sum_o
);

    // Heap layout: node k sums children 2k+1 and 2k+2; indices >= N-1 are leaves.
    logic signed [OW-1:0] leaf   [N];
    logic signed [OW-1:0] node_q [N-1];
    logic signed [OW-1:0] lhs_c  [N-1];
    logic signed [OW-1:0] rhs_c  [N-1];
    logic [LVL-1:0]       vld_q;

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign leaf[i] = OW'($signed(data_i[i*W +: W]));
    end

    for (genvar k = 0; k < N - 1; k++) begin : g_node
        if (2*k + 1 >= N - 1) begin : g_lhs_leaf
            assign lhs_c[k] = leaf[2*k + 1 - (N - 1)];
        end else begin : g_lhs_node
            assign lhs_c[k] = node_q[2*k + 1];
        end
        if (2*k + 2 >= N - 1) begin : g_rhs_leaf
            assign rhs_c[k] = leaf[2*k + 2 - (N - 1)];
        end else begin : g_rhs_node
            assign rhs_c[k] = node_q[2*k + 2];
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int k = 0; k < N - 1; k++) begin
                node_q[k] <= lhs_c[k] + rhs_c[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (en_i) begin
            vld_q[0] <= valid_i;
            for (int k = 1; k < LVL; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign valid_o = vld_q[LVL-1];
    assign sum_o   = node_q[0];

endmodule

// File: rtl/apod_sum.sv
// Delay-and-sum back end: per-channel apodization multiply, pipelined channel
// sum, floor-scaled and saturated output, with scan-line last flagging.
module apod_sum
    import beamform_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int COEF_FRAC  = DEF_COEF_FRAC,
    parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(N_CH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    input  logic                       coef_we,
    input  logic [$clog2(N_CH)-1:0]    coef_addr,
    input  logic [COEF_WIDTH-1:0]      coef_wdata,
    input  logic [15:0]                line_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_last,
    output logic                       out_sat
);

    localparam int AW = $clog2(N_CH);
    localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int TW = PW + AW;

    logic [COEF_WIDTH-1:0]  w_q [N_CH];
    logic signed [PW-1:0]   prod_d [N_CH];
    logic [N_CH*PW-1:0]     prod_q;
    logic                   prod_vld_q;
    logic                   tree_vld;
    logic signed [TW-1:0]   tree_sum;
    logic signed [TW-1:0]   scaled;
    logic signed [63:0]     scaled_ext;
    logic signed [63:0]     clamped;
    logic                   out_valid_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic                   out_sat_q;
    logic [15:0]            cnt_q;
    logic                   en;
    logic                   at_end;

    // Stall only when a result is held waiting for the consumer.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    // Weight writes land at the edge, so a set accepted on that edge sees the old weight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                w_q[i] <= COEF_WIDTH'(1 << COEF_FRAC);
            end
        end else if (coef_we) begin
            w_q[coef_addr] <= coef_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            prod_d[i] = PW'($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]))
                      * PW'($signed({1'b0, w_q[i]}));
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < N_CH; i++) begin
                prod_q[i*PW +: PW] <= prod_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_vld_q <= 1'b0;
        end else if (en) begin
            prod_vld_q <= in_valid;
        end
    end

    adder_tree_pipe #(
        .N (N_CH),
        .W (PW)
    ) u_tree (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .valid_i (prod_vld_q),
        .data_i  (prod_q),
        .valid_o (tree_vld),
        .sum_o   (tree_sum)
    );

    assign scaled     = tree_sum >>> COEF_FRAC;
    assign scaled_ext = 64'(scaled);
    assign clamped    = sat_trunc(scaled_ext, OUT_WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= tree_vld;
            if (tree_vld) begin
                out_data_q <= clamped[OUT_WIDTH-1:0];
                out_sat_q  <= (clamped != scaled_ext);
            end
        end
    end

    // line_len is compared live; a mid-line decrease lets cnt run round through 65535.
    assign at_end = (line_len != 16'd0) && (cnt_q == line_len - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            cnt_q <= at_end ? 16'd0 : cnt_q + 16'd1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_last  = out_valid_q && at_end;

endmodule

// File: tb/tb_apod_sum.sv
// Directed bench for apod_sum: hand-computed vectors plus a small weighted-sum
// model for the randomly back-pressured stream.
module tb_apod_sum;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int CW = 12;
    localparam int OW = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic [CW-1:0]     coef_wdata;
    logic [15:0]       line_len;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              out_last;
    logic              out_sat;

    logic [OW:0]       exp_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                w_m [N];
    logic [15:0]       mcnt = '0;
    int                last_seen = 0;
    int                rx_cnt = 0;
    logic              rnd_ready = 1'b0;

    always #5 clk = ~clk;

    apod_sum dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .line_len   (line_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_sat    (out_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] all_ch(input logic [15:0] v);
        return {N{v}};
    endfunction

    function automatic logic [OW:0] model(input logic [N*DW-1:0] d);
        longint acc = 0;
        logic [15:0] s;
        for (int i = 0; i < N; i++) begin
            s = d[i*DW +: DW];
            acc += longint'($signed(s)) * longint'(w_m[i]);
        end
        acc = acc >>> 11;
        if (acc > 262143) return {1'b1, 19'h3FFFF};
        if (acc < -262144) return {1'b1, 19'h40000};
        return {1'b0, acc[18:0]};
    endfunction

    // Output monitor: sampled 1 time unit after the falling edge.
    always @(negedge clk) begin
        logic       exp_last;
        logic [OW:0] e;
        #1;
        if (!reset) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (out_valid && out_ready) begin
                exp_last = (line_len != 16'd0) && (mcnt == line_len - 16'd1);
                check("out_last", {31'd0, out_last}, {31'd0, exp_last});
                if (exp_last) last_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sat_data", {12'd0, out_sat, out_data}, {12'd0, e});
                end
                mcnt = exp_last ? 16'd0 : mcnt + 16'd1;
                rx_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        mcnt = '0;
        for (int i = 0; i < N; i++) w_m[i] = 2048;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr_coef(input int a, input int v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 3'(a);
        coef_wdata = CW'(v);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        w_m[a]  = v;
    endtask

    // Present one set; optionally write a weight in the very cycle of acceptance.
    task automatic send_set(input logic [N*DW-1:0] d, input logic [OW:0] e,
                            input logic we = 1'b0, input int a = 0, input int v = 0);
        int tries = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = d;
        coef_we    = we;
        coef_addr  = 3'(a);
        coef_wdata = CW'(v);
        #1;
        while (!in_ready && tries < 200) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (we) w_m[a] = v;
    endtask

    task automatic drain();
        int cyc = 0;
        rnd_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        repeat (2) @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int rx0;
        logic [N*DW-1:0] d;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        line_len   = 16'd0;
        out_ready  = 1'b1;
        do_reset();

        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {13'd0, out_data},  32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_out_sat",   {31'd0, out_sat},   32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // 1: unity weights, 8 x 100 -> 800, latency 5
        send_set(all_ch(16'd100), {1'b0, 19'd800});
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        drain();

        // 2: half weight on ch0, -7 -> floor(-3.5) = -4
        wr_coef(3, 0);
        wr_coef(0, 1024);
        send_set({{7{16'd0}}, 16'hFFF9}, {1'b0, 19'h7FFFC});
        drain();

        // 3: max weights, full-scale inputs saturate both ways
        for (int i = 0; i < N; i++) wr_coef(i, 4095);
        send_set(all_ch(16'h7FFF), {1'b1, 19'h3FFFF});
        send_set(all_ch(16'h8000), {1'b1, 19'h40000});
        drain();

        // all-zero weights
        for (int i = 0; i < N; i++) wr_coef(i, 0);
        send_set(all_ch(16'h7FFF), {1'b0, 19'd0});
        drain();

        // 4: random stream under random back-pressure
        for (int i = 0; i < N; i++) wr_coef(i, $urandom_range(0, 4095));
        rx0 = rx_cnt;
        rnd_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) d[i*DW +: DW] = 16'($urandom);
            send_set(d, model(d));
        end
        drain();
        check("stream_count", 32'(rx_cnt - rx0), 32'd20);

        // 5: line_len=4 over 9 sets, then line_len=0
        do_reset();
        line_len  = 16'd4;
        last_seen = 0;
        for (int k = 0; k < 9; k++) send_set(all_ch(16'(k)), {1'b0, 19'(k * 8)});
        drain();
        check("last_count_len4", 32'(last_seen), 32'd2);
        line_len  = 16'd0;
        last_seen = 0;
        for (int k = 0; k < 5; k++) send_set(all_ch(16'd1), {1'b0, 19'd8});
        drain();
        check("last_count_len0", 32'(last_seen), 32'd0);

        // 6: same-cycle weight write uses old weight; reset mid-stream restores unity
        send_set({{7{16'd0}}, 16'd100}, {1'b0, 19'd100}, 1'b1, 0, 0);
        drain();
        send_set({{7{16'd0}}, 16'd100}, {1'b0, 19'd0});
        drain();
        send_set({{7{16'd0}}, 16'd100}, {1'b0, 19'd0});
        send_set({{7{16'd0}}, 16'd100}, {1'b0, 19'd0});
        do_reset();
        #1;
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_flushed", {31'd0, out_valid}, 32'd0);
        send_set({{7{16'd0}}, 16'd100}, {1'b0, 19'd100});
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
